// File: rtl/vx_dispatch_pkg.sv
// Shared definitions for the execution dispatch stage: unit indices,
// thread-id sizing and the lowest-set-bit helper used for lane-id derivation.
package vx_dispatch_pkg;

    localparam int unsigned EX_ALU = 0;
    localparam int unsigned EX_LSU = 1;
    localparam int unsigned EX_CSR = 2;
    localparam int unsigned EX_FPU = 3;
    localparam int unsigned EX_GPU = 4;

    // Widest thread mask the lowest-set-bit helper accepts
    localparam int unsigned MAX_THREADS = 64;

    // Thread-id width; a single-thread build still carries a 1-bit tid
    function automatic int unsigned nt_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Entry layout for the default configuration (4 threads, 64-bit payload)
    typedef struct packed {
        logic [3:0]  tmask;
        logic [1:0]  tid;
        logic [63:0] data;
    } dispatch_entry_t;

    // Index of the lowest set bit; an empty mask yields 0
    function automatic int unsigned lowest_set(input logic [MAX_THREADS-1:0] mask);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = MAX_THREADS; i > 0; i--) begin
            if (mask[i-1]) idx = i - 1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/vx_dispatch_fifo.sv
// Per-unit elastic FIFO: DEPTH entries held in flops, head presented directly
// from storage. Push while full is ignored; simultaneous push+pop keeps count.
module vx_dispatch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = PTRW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;
    logic [CNTW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vx_exec_dispatch.sv
// Issue-stage dispatcher: routes each decoded instruction to the FIFO of the
// execution unit named by in_ex_type, drops NOPs (ex_type >= NUM_UNITS) and
// tags each entry with its lowest active thread id.
// Optional feature macro: DISPATCH_PERF_EN (per-unit stall and NOP counters).
module vx_exec_dispatch
    import vx_dispatch_pkg::*;
#(
    parameter int unsigned NUM_UNITS   = 5,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned DATAW       = 64,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned EX_BITS     = 3
`ifdef DISPATCH_PERF_EN
    ,
    parameter int unsigned PERF_CTR_BITS = 32
`endif
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [EX_BITS-1:0]                    in_ex_type,
    input  logic [NUM_THREADS-1:0]                in_tmask,
    input  logic [DATAW-1:0]                      in_data,
    output logic [NUM_UNITS-1:0]                  out_valid,
    input  logic [NUM_UNITS-1:0]                  out_ready,
    output logic [NUM_UNITS*NUM_THREADS-1:0]      out_tmask,
    output logic [NUM_UNITS*nt_bits(NUM_THREADS)-1:0] out_tid,
    output logic [NUM_UNITS*DATAW-1:0]            out_data
`ifdef DISPATCH_PERF_EN
    ,
    output logic [NUM_UNITS*PERF_CTR_BITS-1:0]    perf_stalls,
    output logic [PERF_CTR_BITS-1:0]              perf_nops
`endif
);

    localparam int unsigned NT_BITS = nt_bits(NUM_THREADS);
    localparam int unsigned SEL_N   = 2 ** EX_BITS;

    typedef struct packed {
        logic [NUM_THREADS-1:0] tmask;
        logic [NT_BITS-1:0]     tid;
        logic [DATAW-1:0]       data;
    } entry_t;

    entry_t               in_entry;
    logic                 sel_unit;
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] full;
    logic [NUM_UNITS-1:0] empty;
    logic [SEL_N-1:0]     full_ext;
    logic [SEL_N-1:0]     push_ext;

    // Lane id is derived once at issue and travels with the entry
    always_comb begin
        in_entry       = '0;
        in_entry.tmask = in_tmask;
        in_entry.tid   = NT_BITS'(lowest_set(MAX_THREADS'(in_tmask)));
        in_entry.data  = in_data;
    end

    // Full flags padded to the whole ex_type range so NOP codes index safely
    assign full_ext = SEL_N'(full);
    assign sel_unit = (32'(in_ex_type) < NUM_UNITS);

    // Ready depends only on registered FIFO state and ex_type; NOPs always accepted
    always_comb begin
        in_ready = 1'b1;
        push_ext = '0;
        if (sel_unit) begin
            in_ready             = ~full_ext[in_ex_type];
            push_ext[in_ex_type] = in_valid & ~full_ext[in_ex_type];
        end
        push = push_ext[NUM_UNITS-1:0];
    end

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        entry_t head;

        vx_dispatch_fifo #(
            .DEPTH (DEPTH),
            .WIDTH ($bits(entry_t))
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[u]),
            .pop   (out_ready[u]),
            .wdata (in_entry),
            .rdata (head),
            .full  (full[u]),
            .empty (empty[u])
        );

        assign out_valid[u]                              = ~empty[u];
        assign out_tmask[u*NUM_THREADS +: NUM_THREADS]   = head.tmask;
        assign out_tid[u*NT_BITS +: NT_BITS]             = head.tid;
        assign out_data[u*DATAW +: DATAW]                = head.data;
    end

`ifdef DISPATCH_PERF_EN
    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_perf
        logic [PERF_CTR_BITS-1:0] stall_q;
        logic                     stall_hit;

        assign stall_hit = in_valid & sel_unit & (32'(in_ex_type) == u) & ~in_ready;

        // Saturating count of cycles this unit's FIFO refused an issue
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stall_q <= '0;
            end else if (stall_hit && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end

        assign perf_stalls[u*PERF_CTR_BITS +: PERF_CTR_BITS] = stall_q;
    end

    logic [PERF_CTR_BITS-1:0] nops_q;

    // Saturating count of accepted-and-dropped NOPs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nops_q <= '0;
        end else if (in_valid && !sel_unit && (nops_q != '1)) begin
            nops_q <= nops_q + 1'b1;
        end
    end

    assign perf_nops = nops_q;
`endif

endmodule

// File: tb/tb_vx_exec_dispatch.sv
// Self-checking bench for vx_exec_dispatch: directed scenarios plus randomized
// traffic compared against a per-unit queue model of the dispatcher.
module tb_vx_exec_dispatch;

    localparam int NU    = 5;
    localparam int DEPTH = 2;
    localparam int DW    = 64;
    localparam int NT    = 4;
    localparam int EXB   = 3;
    localparam int NTB   = 2;
    localparam int PCB   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [EXB-1:0]    in_ex_type;
    logic [NT-1:0]     in_tmask;
    logic [DW-1:0]     in_data;
    logic [NU-1:0]     out_valid;
    logic [NU-1:0]     out_ready;
    logic [NU*NT-1:0]  out_tmask;
    logic [NU*NTB-1:0] out_tid;
    logic [NU*DW-1:0]  out_data;
`ifdef DISPATCH_PERF_EN
    logic [NU*PCB-1:0] perf_stalls;
    logic [PCB-1:0]    perf_nops;
`endif

    always #5 clk = ~clk;

    vx_exec_dispatch #(
        .NUM_UNITS   (NU),
        .DEPTH       (DEPTH),
        .DATAW       (DW),
        .NUM_THREADS (NT),
        .EX_BITS     (EXB)
`ifdef DISPATCH_PERF_EN
        ,
        .PERF_CTR_BITS (PCB)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ex_type (in_ex_type),
        .in_tmask   (in_tmask),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tmask  (out_tmask),
        .out_tid    (out_tid),
        .out_data   (out_data)
`ifdef DISPATCH_PERF_EN
        ,
        .perf_stalls (perf_stalls),
        .perf_nops   (perf_nops)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one queue per unit plus perf tallies
    typedef struct {
        logic [NT-1:0] tm;
        logic [DW-1:0] d;
    } ent_t;

    ent_t    q [NU][$];
    longint  m_stall [NU];
    longint  m_nops;

    function automatic int exp_tid(input logic [NT-1:0] t);
        logic [NT-1:0] low;
        if (t == '0) return 0;
        low = t & (~t + 1'b1);
        return $countones(low - 1'b1);
    endfunction

    task automatic model_clear();
        for (int u = 0; u < NU; u++) begin
            q[u].delete();
            m_stall[u] = 0;
        end
        m_nops = 0;
    endtask

    task automatic check_outputs();
        for (int u = 0; u < NU; u++) begin
            check($sformatf("valid%0d", u), 64'(out_valid[u]), 64'(q[u].size() != 0));
            if (q[u].size() != 0) begin
                check($sformatf("data%0d", u), out_data[u*DW +: DW], q[u][0].d);
                check($sformatf("tmask%0d", u), 64'(out_tmask[u*NT +: NT]), 64'(q[u][0].tm));
                check($sformatf("tid%0d", u), 64'(out_tid[u*NTB +: NTB]), 64'(exp_tid(q[u][0].tm)));
            end
`ifdef DISPATCH_PERF_EN
            check($sformatf("stalls%0d", u), 64'(perf_stalls[u*PCB +: PCB]), 64'(m_stall[u]));
`endif
        end
`ifdef DISPATCH_PERF_EN
        check("nops", 64'(perf_nops), 64'(m_nops));
`endif
    endtask

    // One clock: drive, check at negedge, advance model at the edge
    task automatic cycle(input bit v, input int ex, input logic [NT-1:0] tm,
                         input logic [DW-1:0] d, input logic [NU-1:0] rdy,
                         output bit acc, output logic got_rdy);
        bit exp_ready;
        in_valid   = v;
        in_ex_type = EXB'(ex);
        in_tmask   = tm;
        in_data    = d;
        out_ready  = rdy;
        @(negedge clk);
        check_outputs();
        exp_ready = (ex >= NU) || (q[ex].size() < DEPTH);
        got_rdy   = in_ready;
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        for (int u = 0; u < NU; u++)
            if (q[u].size() != 0 && rdy[u]) void'(q[u].pop_front());
        if (v && ex < NU && !exp_ready) m_stall[ex]++;
        if (acc) begin
            if (ex < NU) q[ex].push_back('{tm: tm, d: d});
            else         m_nops++;
        end
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = '0;
        reset     = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    bit   acc;
    logic rg;

    initial begin
        in_valid   = 1'b0;
        in_ex_type = '0;
        in_tmask   = '0;
        in_data    = '0;
        out_ready  = '0;
        model_clear();
        reset = 1'b1;
        #2;
        check("reset_valid", 64'(out_valid), 64'(0));
        do_reset();

        // Single issue to unit 2 with lane 2 active
        cycle(1, 2, 4'b0100, 64'hA5, '1, acc, rg);
        check("t2_valid", 64'(out_valid[2]), 64'd1);
        check("t2_tid", 64'(out_tid[2*NTB +: NTB]), 64'd2);
        check("t2_data", out_data[2*DW +: DW], 64'hA5);
        cycle(0, 0, '0, '0, '1, acc, rg);

        // Unit 0 backpressured: two accepted, third refused, then drains in order
        cycle(1, 0, 4'b0001, 64'd1, '0, acc, rg);
        cycle(1, 0, 4'b0001, 64'd2, '0, acc, rg);
        cycle(1, 0, 4'b0001, 64'd3, '0, acc, rg);
        check("t3_refused", 64'(rg), 64'd0);
        acc = 1'b0;
        for (int k = 0; k < 5 && !acc; k++) cycle(1, 0, 4'b0001, 64'd3, '1, acc, rg);
        check("t3_accept_later", 64'(rg), 64'd1);
        for (int k = 0; k < 4; k++) cycle(0, 0, '0, '0, '1, acc, rg);

        // Back-to-back issue to unit 4 with consumer always ready
        for (int i = 0; i < 8; i++) begin
            cycle(1, 4, 4'b1000, 64'(100 + i), '1, acc, rg);
            check("t4_ready", 64'(rg), 64'd1);
        end
        cycle(0, 0, '0, '0, '1, acc, rg);

        // NOP code is consumed without reaching any unit
        cycle(1, 7, 4'b1111, 64'hDEAD, '1, acc, rg);
        check("t5_ready", 64'(rg), 64'd1);
        check("t5_no_valid", 64'(out_valid), 64'd0);
`ifdef DISPATCH_PERF_EN
        check("t5_nops", 64'(perf_nops), 64'd1);
`endif

        // Reset asserted while unit 1 holds two entries
        cycle(1, 1, 4'b0010, 64'h11, '0, acc, rg);
        cycle(1, 1, 4'b0010, 64'h22, '0, acc, rg);
        check("t1_filled", 64'(out_valid[1]), 64'd1);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check("t1_async_clear", 64'(out_valid), 64'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 0, '0, '0, '0, acc, rg);
        check("t1_after_release", 64'(out_valid), 64'd0);

        // Unit 3 held full for ten stalled cycles, then a zero-mask issue
        do_reset();
        cycle(1, 3, 4'b0110, 64'h31, '0, acc, rg);
        cycle(1, 3, 4'b0110, 64'h32, '0, acc, rg);
        for (int k = 0; k < 10; k++) cycle(1, 3, 4'b0110, 64'h33, '0, acc, rg);
`ifdef DISPATCH_PERF_EN
        check("t6_stalls", 64'(perf_stalls[3*PCB +: PCB]), 64'd10);
`endif
        cycle(1, 1, 4'b0000, 64'h77, '1, acc, rg);
        check("t6_tid0_valid", 64'(out_valid[1]), 64'd1);
        check("t6_tid0", 64'(out_tid[1*NTB +: NTB]), 64'd0);

        // Randomized traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                  NT'($urandom), {$urandom, $urandom}, NU'($urandom), acc, rg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
